// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational adder between two requesters.
// Optional feature: define ADDER_ARB_SATURATE_EN to clamp Result to all ones on carry-out.
module adder_share_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req0,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic             Req1,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    output logic [WIDTH-1:0] Adder_A,
    output logic [WIDTH-1:0] Adder_B,
    input  logic [WIDTH-1:0] Adder_Sum,
    input  logic             Adder_CO,
    output logic             Ack0,
    output logic             Ack1,
    output logic [WIDTH-1:0] Result,
    output logic             Result_CO,
    output logic             Busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] adder_a_next;
    logic [WIDTH-1:0] adder_b_next;
    logic [WIDTH-1:0] result_next;
    logic             result_co_next;
    logic             ack0_next;
    logic             ack1_next;
    logic             last_grant;
    logic             last_grant_next;
    logic             grant;
    logic             grant_next;
    logic             pick;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= IDLE;
            Adder_A    <= '0;
            Adder_B    <= '0;
            Result     <= '0;
            Result_CO  <= 1'b0;
            Ack0       <= 1'b0;
            Ack1       <= 1'b0;
            last_grant <= 1'b1;
            grant      <= 1'b0;
        end else begin
            state      <= state_next;
            Adder_A    <= adder_a_next;
            Adder_B    <= adder_b_next;
            Result     <= result_next;
            Result_CO  <= result_co_next;
            Ack0       <= ack0_next;
            Ack1       <= ack1_next;
            last_grant <= last_grant_next;
            grant      <= grant_next;
        end
    end

    // On a tie the requester that did not win last time gets the adder.
    always_comb begin
        state_next      = state;
        adder_a_next    = Adder_A;
        adder_b_next    = Adder_B;
        result_next     = Result;
        result_co_next  = Result_CO;
        ack0_next       = 1'b0;
        ack1_next       = 1'b0;
        last_grant_next = last_grant;
        grant_next      = grant;
        pick            = (Req0 && Req1) ? ~last_grant : Req1;

        case (state)
            IDLE: begin
                if (Req0 || Req1) begin
                    grant_next      = pick;
                    last_grant_next = pick;
                    adder_a_next    = pick ? A1 : A0;
                    adder_b_next    = pick ? B1 : B0;
                    state_next      = EXEC;
                end
            end
            EXEC: begin
`ifdef ADDER_ARB_SATURATE_EN
                result_next = Adder_CO ? {WIDTH{1'b1}} : Adder_Sum;
`else
                result_next = Adder_Sum;
`endif
                result_co_next = Adder_CO;
                ack0_next      = ~grant;
                ack1_next      = grant;
                state_next     = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign Busy = (state != IDLE);

endmodule
